// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   Program-counter register and instruction-fetch sequencer. Holds the
//   current PC, presents it to the external PC+4 adder and to instruction
//   memory, and chooses the next PC from the adder result, a branch target
//   or a jump target. Runs a request/ready handshake with instruction memory
//   and reports each accepted fetch one cycle later with a single-cycle
//   FetchValid pulse. Supports hazard stalls and redirect flushes.
//
// Ports:
//   Clk           in   clock, all state changes on the rising edge
//   Rst           in   synchronous active-high reset
//   PCAddResult   in   PCResult + 4 returned by the external adder
//   PCResult      out  current PC (adder IN1 and imem address)
//   Stall         in   hazard stall, blocks fetch acceptance
//   Branch        in   taken-branch redirect request
//   BranchTarget  in   branch destination
//   Jump          in   jump redirect request (wins over Branch)
//   JumpTarget    in   jump destination
//   IMemReq       out  fetch request for address PCResult (state decoded)
//   IMemReady     in   imem accepts the request this cycle
//   FetchValid    out  one-cycle pulse, a fetch was accepted last cycle
//   FetchPC       out  address of the fetch flagged by FetchValid
//   FetchCount    out  number of accepted fetches, wraps
//   Misaligned    out  sticky flag, a redirect target had nonzero bits [1:0]
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [ADDR_WIDTH-1:0]  PCAddResult,
    output logic [ADDR_WIDTH-1:0]  PCResult,
    input  logic                   Stall,
    input  logic                   Branch,
    input  logic [ADDR_WIDTH-1:0]  BranchTarget,
    input  logic                   Jump,
    input  logic [ADDR_WIDTH-1:0]  JumpTarget,
    output logic                   IMemReq,
    input  logic                   IMemReady,
    output logic                   FetchValid,
    output logic [ADDR_WIDTH-1:0]  FetchPC,
    output logic [COUNT_WIDTH-1:0] FetchCount,
    output logic                   Misaligned
);

    // Sequencer states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    logic [1:0]             state;
    logic [1:0]             next_state;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  next_pc;
    logic                   fetch_valid;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [COUNT_WIDTH-1:0] fetch_count;
    logic                   misaligned;

    logic                   redirect;
    logic                   accept;
    logic                   misalign_hit;
    logic [ADDR_WIDTH-1:0]  raw_target;
    logic [ADDR_WIDTH-1:0]  aligned_target;

    // Handshake and redirect decode. Redirects only count once the
    // sequencer has left IDLE. An accept requires an outstanding request,
    // imem ready, and no stall or redirect in the same cycle, so a redirect
    // flushes the request even when imem signals ready.
    always_comb begin
        redirect       = (state != IDLE) && (Jump || Branch);
        accept         = (state == REQ) && IMemReady && !Stall && !Jump && !Branch;
        raw_target     = Jump ? JumpTarget : BranchTarget;
        aligned_target = {raw_target[ADDR_WIDTH-1:2], 2'b00};
        misalign_hit   = redirect && (raw_target[1:0] != 2'b00);
    end

    // Next-PC selection: jump, then branch, then the adder result on an
    // accepted fetch, otherwise hold. The adder result is taken as-is so
    // that wrap-around at the top of the address space is the adder's
    // business, not ours.
    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = aligned_target;
        end else if (accept) begin
            next_pc = PCAddResult;
        end
    end

    // State transitions. A redirect behaves like a fresh start: back to
    // REQ for the new target, or to STALL when a hazard is also present.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                next_state = Stall ? STALL : REQ;
            end
            REQ: begin
                if (Stall) begin
                    next_state = STALL;
                end else begin
                    next_state = REQ;
                end
            end
            STALL: begin
                if (Stall) begin
                    next_state = STALL;
                end else begin
                    next_state = REQ;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered state. FetchValid is simply the accept of the previous
    // cycle, and FetchPC captures the PC that imem took at that moment.
    // Misaligned is sticky until reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_count <= '0;
            misaligned  <= 1'b0;
        end else begin
            state       <= next_state;
            pc          <= next_pc;
            fetch_valid <= accept;
            if (accept) begin
                fetch_pc    <= pc;
                fetch_count <= fetch_count + COUNT_WIDTH'(1);
            end
            if (misalign_hit) begin
                misaligned <= 1'b1;
            end
        end
    end

    // The request is decoded from state only, never from IMemReady.
    assign IMemReq    = (state == REQ);
    assign PCResult   = pc;
    assign FetchValid = fetch_valid;
    assign FetchPC    = fetch_pc;
    assign FetchCount = fetch_count;
    assign Misaligned = misaligned;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Purpose:
//   Self-checking bench for pc_fetch_unit. A table of per-cycle stimulus
//   records with hand-derived expected outputs walks through reset,
//   sequential fetch, wait states, stall, redirect flush and priority,
//   misaligned targets, address wrap and mid-operation reset. Accepted
//   fetches are pushed to a scoreboard queue and popped when the DUT should
//   raise FetchValid. A long hand-written run then wraps FetchCount.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pc_fetch_unit;

    logic        Clk;
    logic        Rst;
    logic [31:0] PCAddResult;
    logic [31:0] PCResult;
    logic        Stall;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        IMemReq;
    logic        IMemReady;
    logic        FetchValid;
    logic [31:0] FetchPC;
    logic [15:0] FetchCount;
    logic        Misaligned;

    int total;
    int bad;

    logic [31:0] sb_queue[$];
    logic        prev_accept;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        jump;
        logic [31:0] jtgt;
        logic        branch;
        logic [31:0] btgt;
        logic        ready;
        logic        chk;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_mis;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs[NVEC];

    pc_fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .COUNT_WIDTH(16)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .PCAddResult (PCAddResult),
        .PCResult    (PCResult),
        .Stall       (Stall),
        .Branch      (Branch),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .IMemReq     (IMemReq),
        .IMemReady   (IMemReady),
        .FetchValid  (FetchValid),
        .FetchPC     (FetchPC),
        .FetchCount  (FetchCount),
        .Misaligned  (Misaligned)
    );

    // External PC+4 adder, wrapping naturally at 32 bits
    assign PCAddResult = PCResult + 32'd4;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Safety net so the bench always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic rst, logic stall, logic jump, logic [31:0] jtgt,
                                logic branch, logic [31:0] btgt, logic ready, logic chk,
                                logic [31:0] e_pc, logic e_req, logic e_mis, logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst;   v.stall = stall; v.jump = jump;   v.jtgt = jtgt;
        v.branch = branch; v.btgt = btgt; v.ready = ready; v.chk = chk;
        v.e_pc = e_pc; v.e_req = e_req; v.e_mis = e_mis; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check the registered
    // outputs that belong to this cycle, then update the scoreboard with the
    // fetch expected to be accepted at the coming rising edge.
    task automatic applyStimulus(input vec_t v);
        logic        exp_fv;
        logic        acc;
        logic [31:0] exp_fpc;
        @(negedge Clk);
        Rst          = v.rst;
        Stall        = v.stall;
        Jump         = v.jump;
        JumpTarget   = v.jtgt;
        Branch       = v.branch;
        BranchTarget = v.btgt;
        IMemReady    = v.ready;
        #1;
        if (v.chk) begin
            checkOutput("PCResult", PCResult, v.e_pc);
            checkOutput("IMemReq", {31'd0, IMemReq}, {31'd0, v.e_req});
            checkOutput("Misaligned", {31'd0, Misaligned}, {31'd0, v.e_mis});
            checkOutput("FetchCount", {16'd0, FetchCount}, {16'd0, v.e_cnt});
            exp_fv = prev_accept;
            checkOutput("FetchValid", {31'd0, FetchValid}, {31'd0, exp_fv});
            if (exp_fv) begin
                if (sb_queue.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL scoreboard: queue empty, FetchPC=%h", FetchPC);
                end else begin
                    exp_fpc = sb_queue.pop_front();
                    checkOutput("FetchPC", FetchPC, exp_fpc);
                end
            end
        end
        acc = v.e_req && v.ready && !v.stall && !v.jump && !v.branch && !v.rst;
        if (acc) begin
            sb_queue.push_back(v.e_pc);
        end
        prev_accept = acc;
    endtask

    initial begin
        vec_t v;
        total        = 0;
        bad          = 0;
        prev_accept  = 1'b0;
        Rst          = 1'b1;
        Stall        = 1'b0;
        Jump         = 1'b0;
        JumpTarget   = '0;
        Branch       = 1'b0;
        BranchTarget = '0;
        IMemReady    = 1'b0;

        //            rst st jp jtgt          br btgt        rdy chk  e_pc          req mis cnt
        vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,      0, 0,   32'h0,        0, 0, 16'd0);
        vecs[1]  = mk(1, 0, 0, 32'h0,        0, 32'h0,      0, 1,   32'h0,        0, 0, 16'd0);
        vecs[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h0,        0, 0, 16'd0);
        vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h0,        1, 0, 16'd0);
        vecs[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h4,        1, 0, 16'd1);
        vecs[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      0, 1,   32'h8,        1, 0, 16'd2);
        vecs[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      0, 1,   32'h8,        1, 0, 16'd2);
        vecs[7]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      0, 1,   32'h8,        1, 0, 16'd2);
        vecs[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h8,        1, 0, 16'd2);
        vecs[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'hC,        1, 0, 16'd3);
        vecs[10] = mk(0, 1, 0, 32'h0,        0, 32'h0,      1, 1,   32'h10,       1, 0, 16'd4);
        vecs[11] = mk(0, 1, 0, 32'h0,        0, 32'h0,      1, 1,   32'h10,       0, 0, 16'd4);
        vecs[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h10,       0, 0, 16'd4);
        vecs[13] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h10,       1, 0, 16'd4);
        vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h14,       1, 0, 16'd5);
        vecs[15] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h18,       1, 0, 16'd6);
        vecs[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h1C,       1, 0, 16'd7);
        vecs[17] = mk(0, 0, 0, 32'h0,        1, 32'h100,    1, 1,   32'h20,       1, 0, 16'd8);
        vecs[18] = mk(0, 0, 1, 32'h200,      1, 32'h300,    1, 1,   32'h100,      1, 0, 16'd8);
        vecs[19] = mk(0, 0, 1, 32'h203,      0, 32'h0,      1, 1,   32'h200,      1, 0, 16'd8);
        vecs[20] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h200,      1, 1, 16'd8);
        vecs[21] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h204,      1, 1, 16'd9);
        vecs[22] = mk(0, 1, 1, 32'h40,       0, 32'h0,      1, 1,   32'h208,      1, 1, 16'd10);
        vecs[23] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h40,       0, 1, 16'd10);
        vecs[24] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h40,       1, 1, 16'd10);
        vecs[25] = mk(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,      1, 1,   32'h44,       1, 1, 16'd11);
        vecs[26] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'hFFFFFFFC, 1, 1, 16'd11);
        vecs[27] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h0,        1, 1, 16'd12);
        vecs[28] = mk(1, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h4,        1, 1, 16'd13);
        vecs[29] = mk(0, 0, 1, 32'h503,      0, 32'h0,      1, 1,   32'h0,        0, 0, 16'd0);
        vecs[30] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h0,        1, 0, 16'd0);
        vecs[31] = mk(0, 0, 0, 32'h0,        0, 32'h0,      1, 1,   32'h4,        1, 0, 16'd1);

        $display("[TB] table-driven sequence");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end

        // Back-to-back accepts until FetchCount wraps from 16'hFFFF to 0
        $display("[TB] counter wrap run");
        for (int k = 0; k <= 65534; k++) begin
            v = mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 1,
                   32'h8 + 32'(k) * 32'd4, 1, 0, 16'(2 + k));
            applyStimulus(v);
        end
        v = mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0004_0004, 1, 0, 16'd1);
        applyStimulus(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and fetch sequencer that feeds the PC+4 adder and consumes its result. Holds the current PC and drives it to the adder (IN1) and the instruction memory. Selects the next PC from the adder output (PCAddResult), a branch target, or a jump target. Runs a request/ready handshake with instruction memory and emits one registered fetch-valid pulse per accepted fetch, with stall and redirect (flush) support.

Parameters:
ADDR_WIDTH, 32, width of PC, targets and PCAddResult
RESET_PC, 32'h0000_0000, PC value loaded on reset
COUNT_WIDTH, 16, width of the accepted-fetch counter

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  synchronous active-high reset
PCAddResult  input  ADDR_WIDTH  PCResult+4 from the adder (combinational return path)
PCResult  output  ADDR_WIDTH  current PC; drives adder IN1 and imem address
Stall  input  1  hazard stall; blocks fetch acceptance
Branch  input  1  taken-branch redirect request
BranchTarget  input  ADDR_WIDTH  branch destination
Jump  input  1  jump redirect request
JumpTarget  input  ADDR_WIDTH  jump destination
IMemReq  output  1  fetch request for address PCResult
IMemReady  input  1  imem accepts request this cycle
FetchValid  output  1  one-cycle pulse: fetch accepted last cycle
FetchPC  output  ADDR_WIDTH  address of the fetch flagged by FetchValid
FetchCount  output  COUNT_WIDTH  number of accepted fetches, wraps
Misaligned  output  1  sticky: a redirect target had nonzero bits [1:0]

Behaviour:
- Clk: single clock. Rst: synchronous, active-high. No async logic.
- Reset (Rst=1 at edge): PCResult=RESET_PC, IMemReq=0, FetchValid=0, FetchPC=0, FetchCount=0, Misaligned=0, state=IDLE. Reset overrides every other input, including mid-fetch; in-flight fetch is dropped, no FetchValid.
- States: IDLE, REQ, STALL.
  - IDLE: IMemReq=0. Next state is STALL if Stall, else REQ. PC holds.
  - REQ: IMemReq=1 and PCResult held stable until accept or redirect. Accept = IMemReady & ~Stall & ~Jump & ~Branch. Stall=1 (no redirect) -> STALL.
  - STALL: IMemReq=0. Stall=0 -> REQ. PC holds.
- IMemReq is a registered/state-decoded output and never depends combinationally on IMemReady.
- Next-PC priority, evaluated in REQ and STALL:
  1. Jump -> JumpTarget.
  2. Branch -> BranchTarget.
  3. Accept -> PCAddResult.
  4. Otherwise hold.
- Redirect is a flush:
  - The current request is discarded: no FetchValid, no count increment, even if IMemReady=1 that cycle.
  - The state machine goes to REQ, or to STALL if Stall=1.
- Redirects in IDLE are ignored.
- Target alignment: the applied target has bits [1:0] forced to 0. If the raw target's [1:0] != 0, Misaligned is set and stays set until Rst.
- Accept latency is 1 cycle. In the cycle after an accept:
  - FetchValid=1 and FetchPC = the PCResult that was accepted.
  - FetchCount has been incremented by 1, wrapping from all-ones to 0.
  - FetchValid is 0 in every other cycle.
- Back-to-back accepts, with IMemReady=1 continuously and no stall, yield one fetch per cycle. PC sequence: RESET_PC, +4, +8, ...
- PC arithmetic is not done locally; the PC uses PCAddResult as given. At ADDR_WIDTH the adder wraps (32'hFFFF_FFFC -> 0), and the block accepts the wrapped value.
- Simultaneous Jump and Branch: Jump wins; only the JumpTarget alignment is checked.
- Stall and redirect in the same cycle: the PC is redirected and the state moves to STALL.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: Rst 2 cycles, then IMemReady=1, no stall/redirect, adder connected.
  - Response: IDLE 1 cycle, then PCResult 0,4,8,12. FetchValid pulses with FetchPC 0,4,8 one cycle after each accept. FetchCount=3 after the third pulse.
- Wait states:
  - Stimulus: IMemReady low for 3 cycles at PC=8.
  - Response: IMemReq=1 and PCResult=8 held for 3 cycles with no FetchValid. On the ready cycle, accept, FetchPC=8 next cycle, then PC=12.
- Stall:
  - Stimulus: Stall=1 for 2 cycles at PC=0x10, IMemReady=1.
  - Response: IMemReq=0 and PC=0x10 held, no pulses. After release, REQ; accept of 0x10 follows.
- Redirect flush and priority:
  - Stimulus 1: at PC=0x20 with IMemReady=1, Branch=1, BranchTarget=0x100.
  - Response 1: no FetchValid for 0x20, FetchCount unchanged, next PCResult=0x100.
  - Stimulus 2: Jump=1 (JumpTarget=0x200) and Branch=1 (BranchTarget=0x300) together.
  - Response 2: PCResult=0x200.
- Misaligned target:
  - Stimulus: Jump=1, JumpTarget=0x203.
  - Response: PCResult=0x200, Misaligned=1 and stays 1 through later normal fetches until Rst.
- Wrap and mid-op reset:
  - Stimulus 1: Jump to 0xFFFF_FFFC, accept.
  - Response 1: next PC=0x0.
  - Stimulus 2: FetchCount preloaded by 65535 accepts, then one more accept.
  - Response 2: FetchCount wraps to 0.
  - Stimulus 3: Rst asserted during REQ with IMemReady=1.
  - Response 3: no FetchValid next cycle, PCResult=RESET_PC.
